// File: rtl/runway_access_scheduler_if.sv
// Signal bundle between the runway scheduler and its controller: request/weather
// inputs on one side, grants, occupancy status and queue depths on the other.
interface runway_access_scheduler_if #(
  parameter int PEND_W = 3
);
  logic              landing_request;
  logic              takeoff_request;
  logic              runway_release;
  logic [1:0]        ECSU_state;
  logic              emergency_landing_alert;
  logic              landing_grant;
  logic              takeoff_grant;
  logic              runway_busy;
  logic              runway_fault;
  logic              queue_overflow;
  logic [PEND_W-1:0] landing_pending;
  logic [PEND_W-1:0] takeoff_pending;
  logic [1:0]        sched_state;

  modport slave (
    input  landing_request, takeoff_request, runway_release, ECSU_state, emergency_landing_alert,
    output landing_grant, takeoff_grant, runway_busy, runway_fault, queue_overflow,
           landing_pending, takeoff_pending, sched_state
  );

  modport master (
    output landing_request, takeoff_request, runway_release, ECSU_state, emergency_landing_alert,
    input  landing_grant, takeoff_grant, runway_busy, runway_fault, queue_overflow,
           landing_pending, takeoff_pending, sched_state
  );
endinterface

// File: rtl/runway_access_scheduler.sv
// Single-runway arbiter: queues landing/takeoff requests, grants one user at a time
// under weather gating with a landing-streak fairness limit, and times out stuck occupancy.
module runway_access_scheduler #(
  parameter int PEND_W      = 3,
  parameter int LAND_STREAK = 3,
  parameter int OCC_TIMEOUT = 16
) (
  input logic                      CLK,
  input logic                      RST,
  runway_access_scheduler_if.slave rw
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LANDING = 2'b01,
    ST_TAKEOFF = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W-1:0] PEND_ONE   = 1;
  localparam logic [3:0]        STREAK_LIM = 4'(LAND_STREAK);
  localparam logic [7:0]        OCC_LIM    = 8'(OCC_TIMEOUT);

  state_t            state, state_nxt;
  logic [3:0]        streak;
  logic [7:0]        occ_timer;
  logic              takeoff_ok, land_go, take_go;
  logic [PEND_W-1:0] lp_nxt, tp_nxt;
  logic              lp_ovf, tp_ovf;

  assign takeoff_ok = !rw.ECSU_state[1] && !rw.emergency_landing_alert;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    land_go   = 1'b0;
    take_go   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rw.landing_pending != '0 &&
            (streak < STREAK_LIM || rw.takeoff_pending == '0 || !takeoff_ok ||
             rw.emergency_landing_alert)) begin
          land_go   = 1'b1;
          state_nxt = ST_LANDING;
        end else if (rw.takeoff_pending != '0 && takeoff_ok) begin
          take_go   = 1'b1;
          state_nxt = ST_TAKEOFF;
        end
      end
      ST_LANDING, ST_TAKEOFF: begin
        if (rw.runway_release)
          state_nxt = ST_IDLE;
        else if (occ_timer + 8'd1 == OCC_LIM)
          state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        if (rw.runway_release)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A request and a dequeue on the same edge cancel; a lone request at max is dropped.
  always_comb begin
    lp_nxt = rw.landing_pending;
    lp_ovf = 1'b0;
    if (rw.landing_request && !land_go) begin
      if (rw.landing_pending == PEND_MAX) lp_ovf = 1'b1;
      else                                lp_nxt = rw.landing_pending + PEND_ONE;
    end else if (!rw.landing_request && land_go) begin
      lp_nxt = rw.landing_pending - PEND_ONE;
    end
  end

  always_comb begin
    tp_nxt = rw.takeoff_pending;
    tp_ovf = 1'b0;
    if (rw.takeoff_request && !take_go) begin
      if (rw.takeoff_pending == PEND_MAX) tp_ovf = 1'b1;
      else                                tp_nxt = rw.takeoff_pending + PEND_ONE;
    end else if (!rw.takeoff_request && take_go) begin
      tp_nxt = rw.takeoff_pending - PEND_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rw.landing_grant   <= 1'b0;
      rw.takeoff_grant   <= 1'b0;
      rw.runway_busy     <= 1'b0;
      rw.runway_fault    <= 1'b0;
      rw.queue_overflow  <= 1'b0;
      rw.landing_pending <= '0;
      rw.takeoff_pending <= '0;
      streak             <= '0;
      occ_timer          <= '0;
    end else begin
      rw.landing_grant   <= land_go;
      rw.takeoff_grant   <= take_go;
      rw.runway_busy     <= (state_nxt != ST_IDLE);
      rw.runway_fault    <= (state_nxt == ST_FAULT);
      rw.queue_overflow  <= lp_ovf | tp_ovf;
      rw.landing_pending <= lp_nxt;
      rw.takeoff_pending <= tp_nxt;

      // Fairness counter only matters while a takeoff is actually waiting.
      if (take_go || rw.takeoff_pending == '0)
        streak <= '0;
      else if (land_go && streak != 4'hF)
        streak <= streak + 4'd1;

      if ((state == ST_LANDING || state == ST_TAKEOFF) && state_nxt == state)
        occ_timer <= occ_timer + 8'd1;
      else
        occ_timer <= '0;
    end
  end

  assign rw.sched_state = state;
endmodule

// File: tb/tb_runway_access_scheduler.sv
// Bench for runway_access_scheduler: directed scenarios plus random traffic, checked against
// an integer-level model; grants go through a scoreboard queue popped by a separate monitor.
module tb_runway_access_scheduler;
  localparam int PEND_W      = 3;
  localparam int LAND_STREAK = 3;
  localparam int OCC_TIMEOUT = 16;
  localparam int PEND_MAX    = (1 << PEND_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  runway_access_scheduler_if #(.PEND_W(PEND_W)) bus ();

  runway_access_scheduler #(
    .PEND_W(PEND_W), .LAND_STREAK(LAND_STREAK), .OCC_TIMEOUT(OCC_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .rw (bus.slave)
  );

  typedef struct {
    int cyc;
    bit land;
  } exp_t;

  exp_t exp_q[$];
  byte  grant_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   ovf_seen = 0;

  // Reference model: plain integers; phase 0 idle, 1 landing, 2 takeoff, 3 fault.
  int m_lp, m_tp, m_streak, m_occ, m_phase;
  bit m_ovf;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit l, input bit t, input bit rel,
                            input int ecsu, input bit emg);
    bit lg = 1'b0;
    bit tg = 1'b0;
    bit ok;
    int lp_new, tp_new;
    if (rst) begin
      m_lp = 0; m_tp = 0; m_streak = 0; m_occ = 0; m_phase = 0; m_ovf = 1'b0;
      return;
    end
    ok = (ecsu <= 1) && !emg;
    if (m_phase == 0) begin
      if (m_lp > 0 && (m_streak < LAND_STREAK || m_tp == 0 || !ok || emg)) lg = 1'b1;
      else if (m_tp > 0 && ok)                                              tg = 1'b1;
    end
    if (tg || m_tp == 0) m_streak = 0;
    else if (lg)         m_streak = (m_streak >= 15) ? 15 : m_streak + 1;

    case (m_phase)
      0: if (lg || tg) begin m_phase = lg ? 1 : 2; m_occ = 0; end
      1, 2: begin
        if (rel) m_phase = 0;
        else begin
          m_occ++;
          if (m_occ >= OCC_TIMEOUT) m_phase = 3;
        end
      end
      default: if (rel) m_phase = 0;
    endcase

    lp_new = m_lp + int'(l) - int'(lg);
    tp_new = m_tp + int'(t) - int'(tg);
    m_ovf  = (lp_new > PEND_MAX) || (tp_new > PEND_MAX);
    m_lp   = (lp_new > PEND_MAX) ? PEND_MAX : lp_new;
    m_tp   = (tp_new > PEND_MAX) ? PEND_MAX : tp_new;
    if (lg || tg) exp_q.push_back('{cyc, lg});
  endtask

  task automatic cycle(input bit l, input bit t, input bit rel, input int ecsu,
                       input bit emg, input bit rst = 1'b0);
    bus.landing_request         = l;
    bus.takeoff_request         = t;
    bus.runway_release          = rel;
    bus.ECSU_state              = 2'(ecsu);
    bus.emergency_landing_alert = emg;
    RST                         = rst;
    @(posedge CLK);
    cyc++;
    model_step(rst, l, t, rel, ecsu, emg);
    #1;
    if (bus.queue_overflow === 1'b1) ovf_seen++;
    check("landing_pending", int'(bus.landing_pending), m_lp);
    check("takeoff_pending", int'(bus.takeoff_pending), m_tp);
    check("sched_state",     int'(bus.sched_state),     m_phase);
    check("runway_busy",     int'(bus.runway_busy),     int'(m_phase != 0));
    check("runway_fault",    int'(bus.runway_fault),    int'(m_phase == 3));
    check("queue_overflow",  int'(bus.queue_overflow),  int'(m_ovf));
  endtask

  // Idle traffic that releases the runway whenever the model says it is occupied.
  task automatic drain(input int n, input int ecsu = 0);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, m_phase != 0, ecsu, 1'b0);
  endtask

  // Monitor: every presented grant is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.landing_grant === 1'b1 || bus.takeoff_grant === 1'b1) begin
        grant_log.push_back(bus.landing_grant === 1'b1 ? "L" : "T");
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("grant_kind",  int'(bus.landing_grant), int'(e.land));
          check("grant_other", int'(bus.takeoff_grant), int'(!e.land));
          check("grant_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        void'(exp_q.pop_front());
        check("grant_missing", 0, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string order;
    int    ovf_before;

    // Reset and single landing.
    cycle(0, 0, 0, 0, 0, 1'b1);
    cycle(0, 0, 0, 0, 0, 1'b1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    drain(3);

    // Fairness: four landings and one takeoff.
    grant_log.delete();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    drain(20);
    order = "LLLTL";
    check("order_len", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("grant_order", int'(grant_log[i]), int'(order[i]));

    // High alert blocks takeoffs but lets the landing through.
    cycle(0, 1, 0, 2, 0);
    cycle(1, 1, 0, 2, 0);
    drain(8, 2);
    check("takeoffs_held", int'(bus.takeoff_pending), 2);
    drain(12, 0);

    // Saturation: hold the runway while eight landings arrive.
    ovf_before = ovf_seen;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("overflow_pulses", ovf_seen - ovf_before, 1);
    check("pending_at_max", int'(bus.landing_pending), PEND_MAX);
    drain(30);

    // Occupancy timeout into FAULT, then release.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < OCC_TIMEOUT + 4; i++) cycle(0, 0, 0, 0, 0);
    check("fault_flag", int'(bus.runway_fault), 1);
    cycle(0, 0, 1, 0, 0);
    drain(3);

    // Reset during a takeoff with three more queued.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1'b1);
    check("reset_state", int'(bus.sched_state), 0);
    drain(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(9, 0) < 3, $urandom_range(9, 0) < 3, $urandom_range(9, 0) < 3,
            $urandom_range(3, 0), $urandom_range(9, 0) == 0, $urandom_range(199, 0) == 0);
    drain(60);

    @(negedge CLK);
    @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
